// File: rtl/hp0_axi_mem_responder.sv
// AXI3 subordinate backing the HP0 master port with a word-addressed on-chip memory.
// One write burst and one read burst may be in flight at once, each run by its own FSM.
module hp0_axi_mem_responder #(
  parameter int C_HP0_AXI_DATA_WIDTH = 32,
  parameter int C_HP0_AXI_ADDR_WIDTH = 32,
  parameter int mem_els_lg_p = 12,
  parameter logic [C_HP0_AXI_ADDR_WIDTH-1:0] base_addr_p = 32'h8000_0000
) (
  input  logic                              aclk,
  input  logic                              reset,

  input  logic [C_HP0_AXI_ADDR_WIDTH-1:0]   hp0_axi_awaddr,
  input  logic                              hp0_axi_awvalid,
  output logic                              hp0_axi_awready,
  input  logic [5:0]                        hp0_axi_awid,
  input  logic [7:0]                        hp0_axi_awlen,
  input  logic [2:0]                        hp0_axi_awsize,
  input  logic [1:0]                        hp0_axi_awburst,
  input  logic                              hp0_axi_awlock,
  input  logic [3:0]                        hp0_axi_awcache,
  input  logic [2:0]                        hp0_axi_awprot,
  input  logic [3:0]                        hp0_axi_awqos,

  input  logic [C_HP0_AXI_DATA_WIDTH-1:0]   hp0_axi_wdata,
  input  logic [C_HP0_AXI_DATA_WIDTH/8-1:0] hp0_axi_wstrb,
  input  logic                              hp0_axi_wvalid,
  output logic                              hp0_axi_wready,
  input  logic [5:0]                        hp0_axi_wid,
  input  logic                              hp0_axi_wlast,

  output logic                              hp0_axi_bvalid,
  input  logic                              hp0_axi_bready,
  output logic [5:0]                        hp0_axi_bid,
  output logic [1:0]                        hp0_axi_bresp,

  input  logic [C_HP0_AXI_ADDR_WIDTH-1:0]   hp0_axi_araddr,
  input  logic                              hp0_axi_arvalid,
  output logic                              hp0_axi_arready,
  input  logic [5:0]                        hp0_axi_arid,
  input  logic [7:0]                        hp0_axi_arlen,
  input  logic [2:0]                        hp0_axi_arsize,
  input  logic [1:0]                        hp0_axi_arburst,
  input  logic                              hp0_axi_arlock,
  input  logic [3:0]                        hp0_axi_arcache,
  input  logic [2:0]                        hp0_axi_arprot,
  input  logic [3:0]                        hp0_axi_arqos,

  output logic [C_HP0_AXI_DATA_WIDTH-1:0]   hp0_axi_rdata,
  output logic                              hp0_axi_rvalid,
  input  logic                              hp0_axi_rready,
  output logic [5:0]                        hp0_axi_rid,
  output logic                              hp0_axi_rlast,
  output logic [1:0]                        hp0_axi_rresp
);

  localparam int aw = C_HP0_AXI_ADDR_WIDTH;
  localparam int dw = C_HP0_AXI_DATA_WIDTH;
  localparam int strb_w = dw / 8;
  localparam logic [aw-1:0] word_bytes = 4;
  localparam logic [1:0] resp_okay = 2'b00;
  localparam logic [1:0] resp_slverr = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;

  logic [dw-1:0] mem [0:(1<<mem_els_lg_p)-1];

  // Holds the address channels closed for the first cycle after reset releases.
  logic ready_q;

  w_state_t w_state, w_next;
  logic [aw-1:0] w_addr;
  logic [5:0]    w_id;
  logic [7:0]    w_len;
  logic [7:0]    w_cnt;
  logic          w_fixed;
  logic          w_suppress;
  logic          w_err;
  logic [aw-1:0] w_off;
  logic [aw-1:0] w_word;
  logic          w_in_range;
  logic [mem_els_lg_p-1:0] w_idx;
  logic          aw_fire;
  logic          w_fire;

  r_state_t r_state, r_next;
  logic [aw-1:0] r_addr;
  logic [5:0]    r_id;
  logic [7:0]    r_len;
  logic [7:0]    r_cnt;
  logic          r_fixed;
  logic          r_err;
  logic [dw-1:0] rdata_q;
  logic [1:0]    rresp_q;
  logic          rlast_q;
  logic          ar_fire;
  logic          r_adv;
  logic          ar_err;
  logic [aw-1:0] ld_addr;
  logic          ld_err;
  logic [aw-1:0] ld_off;
  logic [aw-1:0] ld_word;
  logic          ld_in_range;
  logic [mem_els_lg_p-1:0] ld_idx;

  logic unused_inputs;
  assign unused_inputs = ^{hp0_axi_awlock, hp0_axi_awcache, hp0_axi_awprot, hp0_axi_awqos,
                           hp0_axi_arlock, hp0_axi_arcache, hp0_axi_arprot, hp0_axi_arqos,
                           hp0_axi_wid};

  always_ff @(posedge aclk) begin
    if (reset) ready_q <= 1'b0;
    else       ready_q <= 1'b1;
  end

  // ---------------- write side ----------------
  assign w_off      = w_addr - base_addr_p;
  assign w_word     = w_off >> 2;
  assign w_in_range = (w_addr >= base_addr_p) && ((w_word >> mem_els_lg_p) == '0);
  assign w_idx      = w_word[mem_els_lg_p-1:0];
  assign aw_fire    = hp0_axi_awvalid && hp0_axi_awready;
  assign w_fire     = hp0_axi_wvalid && hp0_axi_wready;

  always_ff @(posedge aclk) begin
    if (reset) w_state <= W_IDLE;
    else       w_state <= w_next;
  end

  always_comb begin
    w_next          = w_state;
    hp0_axi_awready = 1'b0;
    hp0_axi_wready  = 1'b0;
    hp0_axi_bvalid  = 1'b0;
    hp0_axi_bid     = '0;
    hp0_axi_bresp   = resp_okay;
    if (!reset) begin
      case (w_state)
        W_IDLE: begin
          hp0_axi_awready = ready_q;
          if (hp0_axi_awvalid && ready_q) w_next = W_DATA;
        end
        W_DATA: begin
          hp0_axi_wready = 1'b1;
          if (hp0_axi_wvalid && (w_cnt == w_len)) w_next = W_RESP;
        end
        W_RESP: begin
          hp0_axi_bvalid = 1'b1;
          hp0_axi_bid    = w_id;
          hp0_axi_bresp  = w_err ? resp_slverr : resp_okay;
          if (hp0_axi_bready) w_next = W_IDLE;
        end
        default: w_next = W_IDLE;
      endcase
    end
  end

  // The burst length alone ends the burst; a misplaced wlast only taints the response.
  always_ff @(posedge aclk) begin
    if (reset) begin
      w_addr     <= '0;
      w_id       <= '0;
      w_len      <= '0;
      w_cnt      <= '0;
      w_fixed    <= 1'b0;
      w_suppress <= 1'b0;
      w_err      <= 1'b0;
    end else if (aw_fire) begin
      w_addr     <= hp0_axi_awaddr;
      w_id       <= hp0_axi_awid;
      w_len      <= hp0_axi_awlen;
      w_cnt      <= '0;
      w_fixed    <= (hp0_axi_awburst == 2'b00);
      w_suppress <= (hp0_axi_awsize != 3'b010);
      w_err      <= (hp0_axi_awsize != 3'b010) || (hp0_axi_awburst >= 2'b10);
    end else if (w_fire) begin
      w_err <= w_err || !w_in_range || (hp0_axi_wlast != (w_cnt == w_len));
      w_cnt <= w_cnt + 8'd1;
      if (!w_fixed) w_addr <= w_addr + word_bytes;
    end
  end

  always_ff @(posedge aclk) begin
    if (w_fire && w_in_range && !w_suppress) begin
      for (int b = 0; b < strb_w; b++) begin
        if (hp0_axi_wstrb[b]) mem[w_idx][8*b +: 8] <= hp0_axi_wdata[8*b +: 8];
      end
    end
  end

  // ---------------- read side ----------------
  assign ar_fire = hp0_axi_arvalid && hp0_axi_arready;
  assign r_adv   = hp0_axi_rvalid && hp0_axi_rready && !rlast_q;
  assign ar_err  = (hp0_axi_arsize != 3'b010) || (hp0_axi_arburst >= 2'b10);

  // One lookup port serves both the first beat of a new burst and each following beat.
  assign ld_addr     = ar_fire ? hp0_axi_araddr : (r_fixed ? r_addr : r_addr + word_bytes);
  assign ld_err      = ar_fire ? ar_err : r_err;
  assign ld_off      = ld_addr - base_addr_p;
  assign ld_word     = ld_off >> 2;
  assign ld_in_range = (ld_addr >= base_addr_p) && ((ld_word >> mem_els_lg_p) == '0);
  assign ld_idx      = ld_word[mem_els_lg_p-1:0];

  always_ff @(posedge aclk) begin
    if (reset) r_state <= R_IDLE;
    else       r_state <= r_next;
  end

  always_comb begin
    r_next          = r_state;
    hp0_axi_arready = 1'b0;
    hp0_axi_rvalid  = 1'b0;
    hp0_axi_rlast   = 1'b0;
    if (!reset) begin
      case (r_state)
        R_IDLE: begin
          hp0_axi_arready = ready_q;
          if (hp0_axi_arvalid && ready_q) r_next = R_DATA;
        end
        R_DATA: begin
          hp0_axi_rvalid = 1'b1;
          hp0_axi_rlast  = rlast_q;
          if (hp0_axi_rready && rlast_q) r_next = R_IDLE;
        end
        default: r_next = R_IDLE;
      endcase
    end
  end

  // Reading mem here alongside a same-edge write returns the pre-write word.
  always_ff @(posedge aclk) begin
    if (reset) begin
      r_addr  <= '0;
      r_id    <= '0;
      r_len   <= '0;
      r_cnt   <= '0;
      r_fixed <= 1'b0;
      r_err   <= 1'b0;
      rdata_q <= '0;
      rresp_q <= resp_okay;
      rlast_q <= 1'b0;
    end else if (ar_fire || r_adv) begin
      r_addr  <= ld_addr;
      rdata_q <= ld_in_range ? mem[ld_idx] : '0;
      rresp_q <= (ld_err || !ld_in_range) ? resp_slverr : resp_okay;
      if (ar_fire) begin
        r_id    <= hp0_axi_arid;
        r_len   <= hp0_axi_arlen;
        r_cnt   <= '0;
        r_fixed <= (hp0_axi_arburst == 2'b00);
        r_err   <= ar_err;
        rlast_q <= (hp0_axi_arlen == 8'd0);
      end else begin
        r_cnt   <= r_cnt + 8'd1;
        rlast_q <= ((r_cnt + 8'd1) == r_len);
      end
    end
  end

  assign hp0_axi_rdata = rdata_q;
  assign hp0_axi_rid   = r_id;
  assign hp0_axi_rresp = rresp_q;

endmodule

// File: tb/tb_hp0_axi_mem_responder.sv
// Directed bench for hp0_axi_mem_responder: bursts, strobes, errors, stalls, collisions and reset.
module tb_hp0_axi_mem_responder;

  logic        aclk;
  logic        reset;
  logic [31:0] awaddr;
  logic        awvalid, awready;
  logic [5:0]  awid;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid, wready, wlast;
  logic        bvalid, bready;
  logic [5:0]  bid;
  logic [1:0]  bresp;
  logic [31:0] araddr;
  logic        arvalid, arready;
  logic [5:0]  arid;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic [31:0] rdata;
  logic        rvalid, rready, rlast;
  logic [5:0]  rid;
  logic [1:0]  rresp;

  int checks = 0;
  int errors = 0;

  logic [31:0] wdata_vec [0:15];
  logic [3:0]  wstrb_vec [0:15];
  logic [31:0] rd_data [0:15];
  logic [1:0]  rd_resp [0:15];
  logic        rd_last [0:15];
  logic [5:0]  rd_id   [0:15];
  logic [1:0]  b_resp;
  logic [5:0]  b_id;
  int          lat;
  int          rcycles;

  hp0_axi_mem_responder dut (
    .aclk(aclk), .reset(reset),
    .hp0_axi_awaddr(awaddr), .hp0_axi_awvalid(awvalid), .hp0_axi_awready(awready),
    .hp0_axi_awid(awid), .hp0_axi_awlen(awlen), .hp0_axi_awsize(awsize), .hp0_axi_awburst(awburst),
    .hp0_axi_awlock(1'b0), .hp0_axi_awcache(4'h3), .hp0_axi_awprot(3'h0), .hp0_axi_awqos(4'h0),
    .hp0_axi_wdata(wdata), .hp0_axi_wstrb(wstrb), .hp0_axi_wvalid(wvalid), .hp0_axi_wready(wready),
    .hp0_axi_wid(6'h0), .hp0_axi_wlast(wlast),
    .hp0_axi_bvalid(bvalid), .hp0_axi_bready(bready), .hp0_axi_bid(bid), .hp0_axi_bresp(bresp),
    .hp0_axi_araddr(araddr), .hp0_axi_arvalid(arvalid), .hp0_axi_arready(arready),
    .hp0_axi_arid(arid), .hp0_axi_arlen(arlen), .hp0_axi_arsize(arsize), .hp0_axi_arburst(arburst),
    .hp0_axi_arlock(1'b0), .hp0_axi_arcache(4'h3), .hp0_axi_arprot(3'h0), .hp0_axi_arqos(4'h0),
    .hp0_axi_rdata(rdata), .hp0_axi_rvalid(rvalid), .hp0_axi_rready(rready), .hp0_axi_rid(rid),
    .hp0_axi_rlast(rlast), .hp0_axi_rresp(rresp)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
    end
  endtask

  // Runs one write burst from wdata_vec/wstrb_vec; early_beat>=0 moves wlast to that beat.
  task automatic applyWrite(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                            input logic [1:0] burst, input logic [5:0] id,
                            input int early_beat, input int bdelay);
    int n;
    awaddr = addr; awlen = len; awsize = size; awburst = burst; awid = id; awvalid = 1'b1;
    n = 0;
    while (!awready && n < 100) begin @(posedge aclk); #1; n++; end
    checkOutput("awready", awready, 1);
    @(posedge aclk); #1;
    awvalid = 1'b0;
    lat = 0;
    for (int b = 0; b <= int'(len); b++) begin
      wdata = wdata_vec[b]; wstrb = wstrb_vec[b]; wvalid = 1'b1;
      wlast = (early_beat >= 0) ? (b == early_beat) : (b == int'(len));
      n = 0;
      while (!wready && n < 100) begin @(posedge aclk); #1; n++; lat++; end
      checkOutput("wready", wready, 1);
      @(posedge aclk); #1;
      lat++;
    end
    wvalid = 1'b0; wlast = 1'b0;
    n = 0;
    while (!bvalid && n < 100) begin @(posedge aclk); #1; n++; lat++; end
    checkOutput("bvalid", bvalid, 1);
    b_resp = bresp; b_id = bid;
    for (int k = 0; k < bdelay; k++) begin
      @(posedge aclk); #1;
      checkOutput("b_hold", {bvalid, bresp, bid}, {1'b1, b_resp, b_id});
    end
    bready = 1'b1;
    @(posedge aclk); #1;
    bready = 1'b0;
    checkOutput("b_drop", bvalid, 0);
  endtask

  // Runs one read burst into rd_* arrays; with stall set, rready is withheld randomly.
  task automatic applyRead(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                           input logic [1:0] burst, input logic [5:0] id, input bit stall);
    int n;
    int nstall;
    araddr = addr; arlen = len; arsize = size; arburst = burst; arid = id; arvalid = 1'b1;
    n = 0;
    while (!arready && n < 100) begin @(posedge aclk); #1; n++; end
    checkOutput("arready", arready, 1);
    @(posedge aclk); #1;
    arvalid = 1'b0;
    rcycles = 0;
    for (int b = 0; b <= int'(len); b++) begin
      n = 0;
      while (!rvalid && n < 100) begin @(posedge aclk); #1; n++; rcycles++; end
      checkOutput("rvalid", rvalid, 1);
      rd_data[b] = rdata; rd_resp[b] = rresp; rd_last[b] = rlast; rd_id[b] = rid;
      nstall = stall ? int'($urandom_range(1, 3)) : 0;
      for (int k = 0; k < nstall; k++) begin
        @(posedge aclk); #1;
        rcycles++;
        checkOutput("r_hold_ctl", {rvalid, rlast, rresp, rid}, {1'b1, rd_last[b], rd_resp[b], rd_id[b]});
        checkOutput("r_hold_data", rdata, rd_data[b]);
      end
      rready = 1'b1;
      @(posedge aclk); #1;
      rready = 1'b0;
      rcycles++;
    end
  endtask

  task automatic applyStimulus();
    // Reset values
    repeat (3) @(posedge aclk);
    #1;
    checkOutput("rst_ready", {awready, arready, wready}, 3'b000);
    checkOutput("rst_valid", {bvalid, rvalid, rlast}, 3'b000);
    checkOutput("rst_ids", {bid, rid, bresp, rresp}, 16'h0000);
    checkOutput("rst_rdata", rdata, 32'h0);
    reset = 1'b0;
    checkOutput("rel_cycle_ready", {awready, arready}, 2'b00);
    @(posedge aclk); #1;
    checkOutput("post_rst_ready", {awready, arready, wready}, 3'b110);

    // Single write then read
    wdata_vec[0] = 32'hDEAD_BEEF; wstrb_vec[0] = 4'hF;
    applyWrite(32'h8000_0010, 8'd0, 3'd2, 2'b01, 6'd5, -1, 0);
    checkOutput("single_bresp", b_resp, 2'b00);
    checkOutput("single_bid", b_id, 6'd5);
    checkOutput("single_lat", lat, 1);
    applyRead(32'h8000_0010, 8'd0, 3'd2, 2'b01, 6'd9, 1'b0);
    checkOutput("single_rdata", rd_data[0], 32'hDEAD_BEEF);
    checkOutput("single_rctl", {rd_last[0], rd_resp[0], rd_id[0]}, {1'b1, 2'b00, 6'd9});
    checkOutput("single_rcycles", rcycles, 1);

    // INCR len 3
    for (int i = 0; i < 4; i++) begin wdata_vec[i] = 32'(i + 1); wstrb_vec[i] = 4'hF; end
    applyWrite(32'h8000_0000, 8'd3, 3'd2, 2'b01, 6'd12, -1, 0);
    checkOutput("incr_bresp", b_resp, 2'b00);
    checkOutput("incr_lat", lat, 4);
    applyRead(32'h8000_0000, 8'd3, 3'd2, 2'b01, 6'h2A, 1'b0);
    for (int i = 0; i < 4; i++) begin
      checkOutput("incr_rdata", rd_data[i], 32'(i + 1));
      checkOutput("incr_rctl", {rd_last[i], rd_resp[i], rd_id[i]}, {(i == 3), 2'b00, 6'h2A});
    end
    checkOutput("incr_rcycles", rcycles, 4);

    // Byte strobes
    wdata_vec[0] = 32'hFFFF_FFFF; wstrb_vec[0] = 4'hF;
    applyWrite(32'h8000_0020, 8'd0, 3'd2, 2'b01, 6'd1, -1, 0);
    wdata_vec[0] = 32'h1234_5678; wstrb_vec[0] = 4'b0011;
    applyWrite(32'h8000_0020, 8'd0, 3'd2, 2'b01, 6'd1, -1, 0);
    applyRead(32'h8000_0020, 8'd0, 3'd2, 2'b01, 6'd1, 1'b0);
    checkOutput("strb_rdata", rd_data[0], 32'hFFFF_5678);

    // FIXED read returns the same word every beat
    applyRead(32'h8000_0004, 8'd2, 3'd2, 2'b00, 6'd3, 1'b0);
    for (int i = 0; i < 3; i++) begin
      checkOutput("fixed_rdata", rd_data[i], 32'h2);
      checkOutput("fixed_rlast", rd_last[i], (i == 2));
    end

    // Out-of-range write leaves the last word alone; read past the end
    wdata_vec[0] = 32'hCAFE_0001; wstrb_vec[0] = 4'hF;
    applyWrite(32'h8000_3FFC, 8'd0, 3'd2, 2'b01, 6'd2, -1, 0);
    checkOutput("last_word_bresp", b_resp, 2'b00);
    wdata_vec[0] = 32'hBAD0_BAD0;
    applyWrite(32'h7FFF_FFFC, 8'd0, 3'd2, 2'b01, 6'd4, -1, 0);
    checkOutput("oor_bresp", b_resp, 2'b10);
    applyRead(32'h8000_3FFC, 8'd1, 3'd2, 2'b01, 6'd6, 1'b0);
    checkOutput("edge_b0", {rd_data[0], rd_resp[0]}, {32'hCAFE_0001, 2'b00});
    checkOutput("edge_b1", {rd_data[1], rd_resp[1]}, {32'h0, 2'b10});
    checkOutput("edge_last", {rd_last[0], rd_last[1]}, 2'b01);

    // Bad size: SLVERR and no write
    wdata_vec[0] = 32'h1111_1111;
    applyWrite(32'h8000_0010, 8'd0, 3'd1, 2'b01, 6'd7, -1, 0);
    checkOutput("size_bresp", b_resp, 2'b10);
    applyRead(32'h8000_0010, 8'd0, 3'd2, 2'b01, 6'd7, 1'b0);
    checkOutput("size_nowrite", rd_data[0], 32'hDEAD_BEEF);

    // Early wlast on beat 1: still four beats, SLVERR
    for (int i = 0; i < 4; i++) begin wdata_vec[i] = 32'h10 + 32'(i); wstrb_vec[i] = 4'hF; end
    applyWrite(32'h8000_0040, 8'd3, 3'd2, 2'b01, 6'd8, 1, 0);
    checkOutput("early_bresp", b_resp, 2'b10);
    checkOutput("early_lat", lat, 4);
    applyRead(32'h8000_004C, 8'd0, 3'd2, 2'b01, 6'd8, 1'b0);
    checkOutput("early_beat3", rd_data[0], 32'h13);

    // WRAP read: data as INCR, response SLVERR
    applyRead(32'h8000_0000, 8'd0, 3'd2, 2'b10, 6'd10, 1'b0);
    checkOutput("wrap_read", {rd_data[0], rd_resp[0]}, {32'h1, 2'b10});

    // Back-pressure on R and B
    applyRead(32'h8000_0000, 8'd3, 3'd2, 2'b01, 6'h15, 1'b1);
    for (int i = 0; i < 4; i++) checkOutput("stall_rdata", rd_data[i], 32'(i + 1));
    wdata_vec[0] = 32'hAB; wstrb_vec[0] = 4'hF;
    applyWrite(32'h8000_0080, 8'd0, 3'd2, 2'b01, 6'h21, -1, 3);
    checkOutput("stall_b", {b_resp, b_id}, {2'b00, 6'h21});

    // Same-word read load and write in the same cycle
    awaddr = 32'h8000_0000; awlen = 8'd0; awsize = 3'd2; awburst = 2'b01; awid = 6'd3; awvalid = 1'b1;
    checkOutput("coll_awready", awready, 1);
    @(posedge aclk); #1;
    awvalid = 1'b0;
    wdata = 32'h55AA_55AA; wstrb = 4'hF; wlast = 1'b1; wvalid = 1'b1;
    araddr = 32'h8000_0000; arlen = 8'd0; arsize = 3'd2; arburst = 2'b01; arid = 6'd7; arvalid = 1'b1;
    checkOutput("coll_ready", {wready, arready}, 2'b11);
    @(posedge aclk); #1;
    wvalid = 1'b0; wlast = 1'b0; arvalid = 1'b0;
    checkOutput("coll_valid", {rvalid, bvalid}, 2'b11);
    checkOutput("coll_old_data", rdata, 32'h1);
    rready = 1'b1; bready = 1'b1;
    @(posedge aclk); #1;
    rready = 1'b0; bready = 1'b0;
    applyRead(32'h8000_0000, 8'd0, 3'd2, 2'b01, 6'd7, 1'b0);
    checkOutput("coll_new_data", rd_data[0], 32'h55AA_55AA);

    // Reset in the middle of an 8-beat read
    araddr = 32'h8000_0004; arlen = 8'd7; arsize = 3'd2; arburst = 2'b01; arid = 6'd11; arvalid = 1'b1;
    checkOutput("mr_arready", arready, 1);
    @(posedge aclk); #1;
    arvalid = 1'b0; rready = 1'b1;
    @(posedge aclk); #1;
    @(posedge aclk); #1;
    checkOutput("mr_beat2", {rvalid, rdata}, {1'b1, 32'h4});
    reset = 1'b1; rready = 1'b0;
    @(posedge aclk); #1;
    checkOutput("mr_rst_out", {rvalid, rlast, arready, awready}, 4'b0000);
    checkOutput("mr_rst_rdata", rdata, 32'h0);
    reset = 1'b0;
    checkOutput("mr_rel_arready", arready, 0);
    @(posedge aclk); #1;
    checkOutput("mr_post_arready", arready, 1);
    applyRead(32'h8000_0010, 8'd0, 3'd2, 2'b01, 6'd13, 1'b0);
    checkOutput("mr_new_read", {rd_data[0], rd_resp[0], rd_last[0]}, {32'hDEAD_BEEF, 2'b00, 1'b1});
  endtask

  initial begin
    reset = 1'b1;
    awaddr = '0; awvalid = 1'b0; awid = '0; awlen = '0; awsize = '0; awburst = '0;
    wdata = '0; wstrb = '0; wvalid = 1'b0; wlast = 1'b0; bready = 1'b0;
    araddr = '0; arvalid = 1'b0; arid = '0; arlen = '0; arsize = '0; arburst = '0; rready = 1'b0;
    applyStimulus();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hp0_axi_mem_responder.md
# hp0_axi_mem_responder

AXI3 subordinate that answers the HP0 master port of the FPGA shell with a word-addressed on-chip memory. It is the far end of the HP0 interface: reads and writes issued by the design under test land here during cosimulation and bring-up, replacing the PS DRAM path. It supports one write burst and one read burst in flight, each with its own state machine, and reports per-burst error responses.

## Interface
- C_HP0_AXI_DATA_WIDTH, 32: data width; only 32 is supported.
- C_HP0_AXI_ADDR_WIDTH, 32: address width.
- mem_els_lg_p, 12: log2 of memory depth in 32-bit words.
- base_addr_p, 32'h8000_0000: byte address of word 0.

Ports:
- aclk in 1: the single clock.
- reset in 1: synchronous, active-high reset.
- hp0_axi_awaddr in ADDR, hp0_axi_awvalid in 1, hp0_axi_awready out 1, hp0_axi_awid in 6, hp0_axi_awlen in 8, hp0_axi_awsize in 3, hp0_axi_awburst in 2: write address channel.
- hp0_axi_awlock in 1, hp0_axi_awcache in 4, hp0_axi_awprot in 3, hp0_axi_awqos in 4: accepted and ignored. The same applies to the ar* equivalents.
- hp0_axi_wdata in 32, hp0_axi_wstrb in 4, hp0_axi_wvalid in 1, hp0_axi_wready out 1, hp0_axi_wid in 6 (ignored), hp0_axi_wlast in 1: write data channel.
- hp0_axi_bvalid out 1, hp0_axi_bready in 1, hp0_axi_bid out 6, hp0_axi_bresp out 2: write response channel.
- hp0_axi_araddr in ADDR, hp0_axi_arvalid in 1, hp0_axi_arready out 1, hp0_axi_arid in 6, hp0_axi_arlen in 8, hp0_axi_arsize in 3, hp0_axi_arburst in 2: read address channel.
- hp0_axi_rdata out 32, hp0_axi_rvalid out 1, hp0_axi_rready in 1, hp0_axi_rid out 6, hp0_axi_rlast out 1, hp0_axi_rresp out 2: read data channel.

## Operation
- Word index = (addr - base_addr_p) >> 2.
  - A beat is in range iff addr >= base_addr_p and index < 2^mem_els_lg_p.
- Burst types:
  - INCR (2'b01): address += 4 per beat.
  - FIXED (2'b00): address held constant.
  - WRAP (2'b10) and 2'b11: treated as INCR, but the response is SLVERR.
- Size: awsize/arsize != 3'b010 gives SLVERR for the whole burst. Writes in such a burst are suppressed.
- Write FSM, states W_IDLE → W_DATA → W_RESP:
  - W_IDLE: awready=1. On an AW handshake, capture addr, id, len, burst and error flag, then go to W_DATA.
  - W_DATA: wready=1. Each W handshake writes bytes enabled by wstrb to an in-range word; out-of-range beats are dropped and set the error flag. The beat counter runs 0..awlen.
    - A beat whose wlast differs from (count==awlen) sets the error flag.
    - After beat awlen, go to W_RESP. The burst is always exactly awlen+1 beats; wlast never ends it early.
  - W_RESP: bvalid=1, bid=captured id, bresp = error ? 2'b10 : 2'b00. Hold until bready, then go to W_IDLE.
- Read FSM, states R_IDLE → R_DATA:
  - R_IDLE: arready=1. On an AR handshake, capture the request and load the first beat into the output register, then go to R_DATA.
  - R_DATA: rvalid=1; rdata, rresp, rid and rlast stay stable until rready.
    - rlast=1 on beat arlen.
    - Per-beat rresp is 2'b10 if the beat is out of range, or the burst has a size/burst error; otherwise 2'b00.
    - Out-of-range rdata = 0.
    - On a non-final R handshake, load the next beat in the same cycle. On the final one, go to R_IDLE.
- The read and write sides are fully independent and may be active in the same cycle.
- Same-word collision: a word loaded into rdata in the same cycle as a W handshake to that word returns the OLD value.
- Memory contents are not reset.

## Timing
- While reset=1, and in the cycle it deasserts: awready=arready=wready=bvalid=rvalid=rlast=0, bid=rid=0, bresp=rresp=0, rdata=0. Both FSMs are in IDLE.
  - awready and arready go to 1 in the first cycle after reset is sampled low.
- Reset mid-burst abandons the burst with no response. Memory writes already committed remain.
- awready and arready are Moore outputs, 1 only in IDLE, so there is no back-to-back address acceptance.
  - Minimum write: AW at cycle t, W at t+1, bvalid at t+2.
  - Minimum read: AR at cycle t, first rvalid at t+1, next beat valid the cycle after each non-final handshake.
- Throughput with rready and wvalid held high is one beat per cycle.
- Stall: rdata and the other R outputs hold while rvalid=1 and rready=0. bvalid holds until bready.
- A W beat presented before the AW handshake is not accepted (wready=0 in W_IDLE).

## Test plan
- Single write then read: AW addr 0x8000_0010, len 0, size 2, data 0xDEAD_BEEF, strb 4'hF → bresp 0. AR at the same address → rdata 0xDEAD_BEEF, rlast=1, rresp 0.
- INCR burst, len 3: write 0x1..0x4 at 0x8000_0000 with wvalid high throughout → one bresp at the 5th cycle after AW. Read back len 3 → data 1,2,3,4, rlast only on beat 3, rid = arid.
- Strobes and FIXED: write 0xFFFF_FFFF, then 0x1234_5678 with strb 4'b0011 → readback 0xFFFF_5678. A FIXED len-2 read → three identical beats.
- Errors:
  - Write at 0x7FFF_FFFC → bresp 2'b10, memory unchanged.
  - Read burst len 1 starting at the last word → rresp 0 then 2'b10, second rdata 0.
  - awsize 1 → SLVERR, no write.
  - wlast early on beat 1 of len 3 → 4 beats accepted, bresp 2'b10.
- Back-pressure and concurrency:
  - Randomized rready/bready stalls → outputs stable while stalled.
  - Simultaneous read and write to the same word → old value returned.
- Reset mid-read (beat 2 of 8) → rvalid=0 next cycle, arready=1 the cycle after reset is released, then a new read succeeds.
